ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX register and driving the EX/MEM boundary. It decodes the ALU operation and operand sources, computes the ALU result, zero flag, branch target and destination register, and registers them together with the forwarded MEM/WB control bits. A 32-cycle iterative multiplier handles MUL; while it runs, the block raises a stall toward the hazard unit so upstream holds PC and IF/ID and feeds bubbles into ID/EX.

---
 rtl/ex_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target and destination select feeding the EX/MEM register,
// plus a one-bit-per-cycle shift-add multiplier that stalls the front end while it runs.
module ex_stage #(
    parameter int NB_ALU_OP = 3,
    parameter int NB_DATA   = 32,
    parameter int NB_PC     = 32,
    parameter int NB_REG    = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    input  logic                 EX_reg_write,
    input  logic                 EX_mem_to_reg,
    input  logic                 EX_mem_read,
    input  logic                 EX_mem_write,
    input  logic                 EX_branch,
    input  logic                 EX_alu_src,
    input  logic                 EX_reg_dest,
    input  logic [NB_ALU_OP-1:0] EX_alu_op,
    input  logic [NB_PC-1:0]     EX_pc,
    input  logic [NB_DATA-1:0]   EX_data_a,
    input  logic [NB_DATA-1:0]   EX_data_b,
    input  logic [NB_DATA-1:0]   EX_immediate,
    input  logic [NB_REG-1:0]    EX_rt,
    input  logic [NB_REG-1:0]    EX_rd,
    output logic                 MEM_reg_write,
    output logic                 MEM_mem_to_reg,
    output logic                 MEM_mem_read,
    output logic                 MEM_mem_write,
    output logic                 MEM_branch,
    output logic                 MEM_zero,
    output logic [NB_DATA-1:0]   MEM_alu_result,
    output logic [NB_DATA-1:0]   MEM_store_data,
    output logic [NB_PC-1:0]     MEM_branch_target,
    output logic [NB_REG-1:0]    MEM_write_reg,
    output logic                 o_stall
);

    localparam int NB_CNT = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] LAST_STEP = NB_CNT'(NB_DATA - 1);

    localparam logic [NB_ALU_OP-1:0] OP_ADD   = NB_ALU_OP'(0);
    localparam logic [NB_ALU_OP-1:0] OP_SUB   = NB_ALU_OP'(1);
    localparam logic [NB_ALU_OP-1:0] OP_RTYPE = NB_ALU_OP'(2);
    localparam logic [NB_ALU_OP-1:0] OP_AND   = NB_ALU_OP'(3);
    localparam logic [NB_ALU_OP-1:0] OP_OR    = NB_ALU_OP'(4);
    localparam logic [NB_ALU_OP-1:0] OP_XOR   = NB_ALU_OP'(5);
    localparam logic [NB_ALU_OP-1:0] OP_SLT   = NB_ALU_OP'(6);
    localparam logic [NB_ALU_OP-1:0] OP_LUI   = NB_ALU_OP'(7);

    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // ctrl order: {reg_write, mem_to_reg, mem_read, mem_write, branch}
    typedef struct packed {
        logic [4:0]         ctrl;
        logic               zero;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] store_data;
        logic [NB_PC-1:0]   branch_target;
        logic [NB_REG-1:0]  write_reg;
    } exmem_t;

    typedef struct packed {
        logic [4:0]         ctrl;
        logic [NB_DATA-1:0] store_data;
        logic [NB_PC-1:0]   branch_target;
        logic [NB_REG-1:0]  write_reg;
    } mul_ctx_t;

    state_t              state_q, state_d;
    logic [NB_CNT-1:0]   count_q, count_d;
    logic [NB_DATA-1:0]  mcand_q, mcand_d;
    logic [NB_DATA-1:0]  mplier_q, mplier_d;
    logic [NB_DATA-1:0]  prod_q, prod_d;
    mul_ctx_t            ctx_q, ctx_d;
    exmem_t              exmem_q, exmem_d;

    logic [NB_DATA-1:0]  operand_b;
    logic [NB_DATA-1:0]  diff;
    logic [NB_DATA-1:0]  alu_result;
    logic [NB_PC-1:0]    branch_target;
    logic [NB_REG-1:0]   write_reg;
    logic [4:0]          ex_ctrl;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic [4:0]          vshamt;
    logic                slt_s;
    logic                slt_u;
    logic                is_mul;

    assign operand_b     = EX_alu_src ? EX_immediate : EX_data_b;
    assign diff          = EX_data_a - operand_b;
    assign funct         = EX_immediate[5:0];
    assign shamt         = EX_immediate[10:6];
    assign vshamt        = EX_data_a[4:0];
    assign slt_s         = $signed(EX_data_a) < $signed(operand_b);
    assign slt_u         = EX_data_a < operand_b;
    assign is_mul        = (EX_alu_op == OP_RTYPE) && (funct == FN_MUL);
    assign branch_target = EX_pc + (NB_PC'($signed(EX_immediate)) << 2);
    assign write_reg     = EX_reg_dest ? EX_rd : EX_rt;
    assign ex_ctrl       = {EX_reg_write, EX_mem_to_reg, EX_mem_read, EX_mem_write, EX_branch};

    always_comb begin
        alu_result = '0;
        case (EX_alu_op)
            OP_ADD: alu_result = EX_data_a + operand_b;
            OP_SUB: alu_result = diff;
            OP_RTYPE: begin
                case (funct)
                    6'b100000, 6'b100001: alu_result = EX_data_a + operand_b;
                    6'b100010, 6'b100011: alu_result = diff;
                    6'b100100: alu_result = EX_data_a & operand_b;
                    6'b100101: alu_result = EX_data_a | operand_b;
                    6'b100110: alu_result = EX_data_a ^ operand_b;
                    6'b100111: alu_result = ~(EX_data_a | operand_b);
                    6'b101010: alu_result = NB_DATA'(slt_s);
                    6'b101011: alu_result = NB_DATA'(slt_u);
                    6'b000000: alu_result = operand_b << shamt;
                    6'b000010: alu_result = operand_b >> shamt;
                    6'b000011: alu_result = $unsigned($signed(operand_b) >>> shamt);
                    6'b000100: alu_result = operand_b << vshamt;
                    6'b000110: alu_result = operand_b >> vshamt;
                    6'b000111: alu_result = $unsigned($signed(operand_b) >>> vshamt);
                    default:   alu_result = '0;
                endcase
            end
            OP_AND: alu_result = EX_data_a & operand_b;
            OP_OR:  alu_result = EX_data_a | operand_b;
            OP_XOR: alu_result = EX_data_a ^ operand_b;
            OP_SLT: alu_result = NB_DATA'(slt_s);
            OP_LUI: alu_result = operand_b << 16;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        ctx_d    = ctx_q;
        exmem_d  = '0;
        o_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    // EX/MEM takes a bubble while the operands are captured for iteration
                    o_stall             = 1'b1;
                    mcand_d             = EX_data_a;
                    mplier_d            = operand_b;
                    prod_d              = '0;
                    count_d             = '0;
                    ctx_d.ctrl          = ex_ctrl;
                    ctx_d.store_data    = EX_data_b;
                    ctx_d.branch_target = branch_target;
                    ctx_d.write_reg     = write_reg;
                    state_d             = BUSY;
                end else begin
                    exmem_d.ctrl          = ex_ctrl;
                    exmem_d.zero          = (diff == '0);
                    exmem_d.alu_result    = alu_result;
                    exmem_d.store_data    = EX_data_b;
                    exmem_d.branch_target = branch_target;
                    exmem_d.write_reg     = write_reg;
                end
            end
            BUSY: begin
                o_stall  = 1'b1;
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (count_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                exmem_d.ctrl          = ctx_q.ctrl;
                exmem_d.alu_result    = prod_q;
                exmem_d.store_data    = ctx_q.store_data;
                exmem_d.branch_target = ctx_q.branch_target;
                exmem_d.write_reg     = ctx_q.write_reg;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A flush squashes whatever EX holds, including a multiply in flight
        if (i_flush) begin
            state_d = IDLE;
            count_d = '0;
            exmem_d = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            ctx_q    <= '0;
            exmem_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            ctx_q    <= ctx_d;
            exmem_q  <= exmem_d;
        end
    end

    assign {MEM_reg_write, MEM_mem_to_reg, MEM_mem_read, MEM_mem_write, MEM_branch} = exmem_q.ctrl;
    assign MEM_zero          = exmem_q.zero;
    assign MEM_alu_result    = exmem_q.alu_result;
    assign MEM_store_data    = exmem_q.store_data;
    assign MEM_branch_target = exmem_q.branch_target;
    assign MEM_write_reg     = exmem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU vectors, then reset, multiply and flush sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic [4:0]  ex_ctrl;
    logic        alu_src, reg_dest;
    logic [2:0]  alu_op;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rt, rd;

    logic        m_rw, m_mtr, m_mr, m_mw, m_br, m_zero, stall;
    logic [31:0] m_res, m_store, m_tgt;
    logic [4:0]  m_wr;
    logic [4:0]  mem_ctrl;
    assign mem_ctrl = {m_rw, m_mtr, m_mr, m_mw, m_br};

    ex_stage dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
        .EX_reg_write(ex_ctrl[4]), .EX_mem_to_reg(ex_ctrl[3]), .EX_mem_read(ex_ctrl[2]),
        .EX_mem_write(ex_ctrl[1]), .EX_branch(ex_ctrl[0]),
        .EX_alu_src(alu_src), .EX_reg_dest(reg_dest), .EX_alu_op(alu_op),
        .EX_pc(pc), .EX_data_a(a), .EX_data_b(b), .EX_immediate(imm),
        .EX_rt(rt), .EX_rd(rd),
        .MEM_reg_write(m_rw), .MEM_mem_to_reg(m_mtr), .MEM_mem_read(m_mr),
        .MEM_mem_write(m_mw), .MEM_branch(m_br), .MEM_zero(m_zero),
        .MEM_alu_result(m_res), .MEM_store_data(m_store),
        .MEM_branch_target(m_tgt), .MEM_write_reg(m_wr), .o_stall(stall)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, imm, pc;
        logic        src, dst;
        logic [4:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic [31:0] tgt;
        logic [4:0]  wr;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive_idle();
        ex_ctrl = '0; alu_src = 0; reg_dest = 0; alu_op = '0;
        pc = '0; a = '0; b = '0; imm = '0; rt = 5'd3; rd = 5'd9;
    endtask

    task automatic drive_vec(input vec_t v);
        ex_ctrl = v.ctrl; alu_src = v.src; reg_dest = v.dst; alu_op = v.op;
        pc = v.pc; a = v.a; b = v.b; imm = v.imm; rt = 5'd3; rd = 5'd9;
    endtask

    task automatic drive_mul();
        ex_ctrl = 5'b10000; alu_src = 0; reg_dest = 1; alu_op = 3'b010;
        pc = 32'h400; a = 32'hFFFFFFFF; b = 32'd3; imm = 32'h18; rt = 5'd3; rd = 5'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt, bubble_bad, done_seen, leak;

        //        op      a             b             imm           pc            src dst ctrl      res           z  tgt           wr
        vecs[0]  = '{3'd2, 32'd5,        32'd7,        32'h22,       32'h100,      0, 1, 5'b10000, 32'hFFFFFFFE, 0, 32'h188,     5'd9};
        vecs[1]  = '{3'd1, 32'h1234,     32'h1234,     32'hFFFFFFFF, 32'h100,      0, 0, 5'b00001, 32'h0,        1, 32'hFC,      5'd3};
        vecs[2]  = '{3'd2, 32'h0,        32'h80000000, 32'h103,      32'h100,      0, 1, 5'b11000, 32'hF8000000, 0, 32'h50C,     5'd9};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd1,        32'h2A,       32'h100,      0, 1, 5'b10000, 32'd1,        0, 32'h1A8,     5'd9};
        vecs[4]  = '{3'd2, 32'hFFFFFFFF, 32'd1,        32'h2B,       32'h100,      0, 1, 5'b00100, 32'd0,        0, 32'h1AC,     5'd9};
        vecs[5]  = '{3'd7, 32'h0,        32'hDEAD0000, 32'h1234,     32'h100,      1, 0, 5'b11000, 32'h12340000, 0, 32'h49D0,    5'd3};
        vecs[6]  = '{3'd0, 32'hFFFFFFFF, 32'h55,       32'h1,        32'h100,      1, 0, 5'b10000, 32'h0,        0, 32'h104,     5'd3};
        vecs[7]  = '{3'd2, 32'h0F0F0000, 32'h00FF00FF, 32'h27,       32'h100,      0, 1, 5'b10000, 32'hF000FF00, 0, 32'h19C,     5'd9};
        vecs[8]  = '{3'd2, 32'h4,        32'h1,        32'h4,        32'h100,      0, 1, 5'b10000, 32'h10,       0, 32'h110,     5'd9};
        vecs[9]  = '{3'd2, 32'h0,        32'h80000000, 32'h202,      32'h100,      0, 1, 5'b10000, 32'h00800000, 0, 32'h908,     5'd9};
        vecs[10] = '{3'd2, 32'h1,        32'h1,        32'h3F,       32'h100,      0, 1, 5'b10110, 32'h0,        1, 32'h1FC,     5'd9};
        vecs[11] = '{3'd5, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h100,      0, 0, 5'b00010, 32'hF0F0F0F0, 0, 32'h100,     5'd3};
        vecs[12] = '{3'd2, 32'h24,       32'hF0000000, 32'h7,        32'h100,      0, 1, 5'b10000, 32'hFF000000, 0, 32'h11C,     5'd9};
        vecs[13] = '{3'd3, 32'h1234FFFF, 32'h77,       32'hFF0F,     32'h100,      1, 0, 5'b00100, 32'h0000FF0F, 0, 32'h3FD3C,   5'd3};
        vecs[14] = '{3'd4, 32'hF0,       32'h0F,       32'h0,        32'h2000,     0, 0, 5'b10000, 32'hFF,       0, 32'h2000,    5'd3};
        vecs[15] = '{3'd1, 32'h0,        32'h1,        32'h2,        32'hFFFFFFFC, 0, 0, 5'b01000, 32'hFFFFFFFF, 0, 32'h4,       5'd3};

        rst_n = 1'b0; flush = 1'b0;
        drive_idle();
        #1;
        check("reset_ctrl", {27'd0, mem_ctrl}, 32'd0);
        check("reset_res", m_res, 32'd0);
        check("reset_tgt", m_tgt, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive_vec(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("v%0d_res", i), m_res, vecs[i].res);
            check($sformatf("v%0d_zero", i), {31'd0, m_zero}, {31'd0, vecs[i].zero});
            check($sformatf("v%0d_tgt", i), m_tgt, vecs[i].tgt);
            check($sformatf("v%0d_wr", i), {27'd0, m_wr}, {27'd0, vecs[i].wr});
            check($sformatf("v%0d_ctrl", i), {27'd0, mem_ctrl}, {27'd0, vecs[i].ctrl});
            check($sformatf("v%0d_store", i), m_store, vecs[i].b);
            $display("vec %0d op=%0d a=%h b=%h imm=%h -> res=%h zero=%0d tgt=%h wr=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, m_res, m_zero, m_tgt, m_wr);
        end

        // asynchronous reset in the middle of a cycle
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", {27'd0, mem_ctrl}, 32'd0);
        check("async_rst_res", m_res, 32'd0);
        check("async_rst_zero_tgt", {m_zero, m_tgt[30:0]}, 32'd0);
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        $display("async reset mid-cycle: ctrl=%b res=%h stall=%0d", mem_ctrl, m_res, stall);
        #2 rst_n = 1'b1;

        // multiply -1 * 3 with unrelated instructions presented while busy
        drive_mul();
        #1;
        stall_cnt = 0; bubble_bad = 0; done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (!stall) begin
                done_seen = 1;
                break;
            end
            stall_cnt++;
            @(posedge clk); #1;
            if (mem_ctrl !== 5'b0) bubble_bad++;
            ex_ctrl = 5'b11111; alu_op = 3'd0; a = 32'd7; b = 32'd8; imm = 32'd0; rd = 5'd17;
        end
        check("mul_stall_ends", done_seen, 1);
        check("mul_stall_cycles", stall_cnt, 33);
        check("mul_bubbles", bubble_bad, 0);
        drive_idle();
        @(posedge clk); #1;
        check("mul_res", m_res, 32'hFFFFFFFD);
        check("mul_wr", {27'd0, m_wr}, 32'd4);
        check("mul_ctrl", {27'd0, mem_ctrl}, 32'b10000);
        check("mul_zero", {31'd0, m_zero}, 32'd0);
        check("mul_store", m_store, 32'd3);
        check("mul_tgt", m_tgt, 32'h460);
        $display("mul result: res=%h wr=%0d ctrl=%b stall_cycles=%0d", m_res, m_wr, mem_ctrl, stall_cnt);
        @(posedge clk); #1;
        check("mul_one_cycle", {27'd0, mem_ctrl}, 32'd0);

        // flush at busy count 10
        drive_mul();
        @(posedge clk); #1;
        drive_idle();
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_stall_drop", {31'd0, stall}, 32'd0);
        check("flush_ctrl", {27'd0, mem_ctrl}, 32'd0);
        leak = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (stall || m_rw || (m_res == 32'hFFFFFFFD)) leak++;
        end
        check("flush_no_result", leak, 0);
        $display("flush during mul: stall=%0d ctrl=%b leak=%0d", stall, mem_ctrl, leak);

        ex_ctrl = 5'b10000; alu_op = 3'd0; a = 32'd2; b = 32'd3; imm = 32'd0; reg_dest = 1; rd = 5'd12;
        @(posedge clk); #1;
        check("post_flush_add", m_res, 32'd5);
        check("post_flush_ctrl", {27'd0, mem_ctrl}, 32'b10000);
        check("post_flush_wr", {27'd0, m_wr}, 32'd12);
        $display("post-flush add: res=%h ctrl=%b wr=%0d", m_res, mem_ctrl, m_wr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
